plru_tree_n: RTL and testbench

//   Parametrised tree pseudo-LRU replacement state for an N-way set-associative cache.

---
 rtl/plru_tree_n.sv | 123 ++++++++++++
 tb/tb_plru_tree_n.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/plru_tree_n.sv
// Tree pseudo-LRU state per set: invalid-first victim choice, tree walk otherwise, one-set-per-cycle flush.
// Define PLRU_WAY_LOCK_EN to add the lock_mask port that excludes ways from victim selection.
module plru_tree_n #(
  parameter int WAYS  = 8,
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_index,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] query_index,
  input  logic [WAYS-1:0]  valid_vec,
`ifdef PLRU_WAY_LOCK_EN
  input  logic [WAYS-1:0]  lock_mask,
`endif
  input  logic             flush_req,
  output logic             busy,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_valid
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WAYS-2:0]  tree_q [SETS];
  logic [WAYS-2:0]  tree_d [SETS];
  logic [WAYS-1:0]  lock_w;
  logic [WAY_W-1:0] inv_way, walk_way;
  logic             inv_found, all_locked;

`ifdef PLRU_WAY_LOCK_EN
  assign lock_w = lock_mask;
`else
  assign lock_w = '0;
`endif

  always_comb begin : next_state
    int               tw;
    logic [WAY_W-1:0] node;
    state_d = state_q;
    cnt_d   = cnt_q;
    tree_d  = tree_q;
    tw      = 0;
    node    = '0;
    if (state_q == FLUSH) begin
      // Touches and flush requests are dropped while sweeping.
      tree_d[cnt_q] = '0;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
    end else begin
      if (touch_valid) begin
        for (int l = 0; l < WAY_W; l++) begin
          tw   = int'(touch_way) >> (WAY_W - 1 - l);
          node = WAY_W'((1 << l) - 1 + (tw >> 1));
          tree_d[touch_index][node] = ~tw[0];
        end
      end
      if (flush_req) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
    end
    busy_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
    end
  end

  always_comb begin : victim_sel
    logic [WAYS-2:0]  t;
    logic [WAYS-1:0]  sub_mask;
    logic [WAY_W-1:0] node;
    logic             dir;
    int               pos;
    int               size;
    t         = tree_q[query_index];
    inv_found = 1'b0;
    inv_way   = '0;
    sub_mask  = '0;
    node      = '0;
    dir       = 1'b0;
    pos       = 0;
    size      = 0;
    for (int i = 0; i < WAYS; i++) begin
      if (!inv_found && !valid_vec[i] && !lock_w[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
    // Walk follows the stored bit unless the whole preferred subtree is locked.
    for (int l = 0; l < WAY_W; l++) begin
      size     = WAYS >> (l + 1);
      node     = WAY_W'((1 << l) - 1 + pos);
      dir      = t[node];
      sub_mask = {WAYS{1'b1}} >> (WAYS - size);
      if (((lock_w >> ((2 * pos + int'(dir)) * size)) & sub_mask) == sub_mask) dir = ~dir;
      pos = 2 * pos + int'(dir);
    end
    walk_way   = WAY_W'(pos);
    all_locked = &lock_w;
  end

  assign busy         = busy_q;
  assign victim_way   = all_locked ? '0 : (inv_found ? inv_way : walk_way);
  assign victim_valid = !busy_q && !all_locked;

endmodule

// File: tb/tb_plru_tree_n.sv
// Directed bench for plru_tree_n (WAYS=8, SETS=8) with hand-computed expected victims.
module tb_plru_tree_n;
  localparam int WAYS  = 8;
  localparam int SETS  = 8;
  localparam int IDX_W = 3;
  localparam int WAY_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             touch_valid = 1'b0;
  logic [IDX_W-1:0] touch_index = '0;
  logic [WAY_W-1:0] touch_way = '0;
  logic [IDX_W-1:0] query_index = '0;
  logic [WAYS-1:0]  valid_vec = '1;
`ifdef PLRU_WAY_LOCK_EN
  logic [WAYS-1:0]  lock_mask = '0;
`endif
  logic             flush_req = 1'b0;
  logic             busy;
  logic [WAY_W-1:0] victim_way;
  logic             victim_valid;

  int n_vec = 0;
  int n_err = 0;

  plru_tree_n #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .touch_valid  (touch_valid),
    .touch_index  (touch_index),
    .touch_way    (touch_way),
    .query_index  (query_index),
    .valid_vec    (valid_vec),
`ifdef PLRU_WAY_LOCK_EN
    .lock_mask    (lock_mask),
`endif
    .flush_req    (flush_req),
    .busy         (busy),
    .victim_way   (victim_way),
    .victim_valid (victim_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input int idx, input int way);
    touch_valid = 1'b1;
    touch_index = IDX_W'(idx);
    touch_way   = WAY_W'(way);
    tick();
    touch_valid = 1'b0;
  endtask

  task automatic chk_vict(input string tag, input int idx, input int exp);
    query_index = IDX_W'(idx);
    #1;
    chk(tag, int'(victim_way), exp);
  endtask

  initial begin
    // Reset state
    query_index = 3'd3;
    #1;
    chk("rst_way", int'(victim_way), 0);
    chk("rst_vld", int'(victim_valid), 1);
    chk("rst_busy", int'(busy), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", int'(busy), 0);

    // Touch ways 0..7 on set 2: tree points back at way 0
    for (int w = 0; w < WAYS; w++) touch(2, w);
    chk_vict("s2_after_seq", 2, 0);
    // Same-cycle collision: pre-touch state visible, new state next cycle
    touch_valid = 1'b1; touch_index = 3'd2; touch_way = 3'd0;
    chk_vict("s2_collide", 2, 0);
    tick();
    touch_valid = 1'b0;
    chk_vict("s2_touch0", 2, 4);
    chk_vict("s3_untouched", 3, 0);

    // Invalid-way priority overrides the tree walk
    valid_vec = 8'b1111_0111;
    chk_vict("inv_way3", 2, 3);
    valid_vec = 8'b0111_1111;
    chk_vict("inv_way7", 2, 7);
    valid_vec = 8'b1111_0000;
    chk_vict("inv_lowest", 2, 0);
    valid_vec = 8'hFF;

    // Flush: busy exactly SETS cycles, touches and extra flush_req dropped
    touch(5, 0);
    chk_vict("s5_pre_flush", 5, 4);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < SETS; k++) begin
      if (k == 3) flush_req = 1'b1;
      if (k == 5) begin touch_valid = 1'b1; touch_index = 3'd5; touch_way = 3'd4; end
      if (k == 7) begin touch_valid = 1'b1; touch_index = 3'd5; touch_way = 3'd0; end
      #1;
      chk($sformatf("flush_busy%0d", k), int'(busy), 1);
      chk($sformatf("flush_vld%0d", k), int'(victim_valid), 0);
      tick();
      flush_req = 1'b0;
      touch_valid = 1'b0;
    end
    chk("flush_done_busy", int'(busy), 0);
    chk("flush_done_vld", int'(victim_valid), 1);
    chk_vict("s5_after_flush", 5, 0);
    chk_vict("s2_after_flush", 2, 0);
    tick();
    chk("flush_no_extend", int'(busy), 0);

    // Collision on set 1 from cleared state
    touch_valid = 1'b1; touch_index = 3'd1; touch_way = 3'd0;
    chk_vict("s1_collide", 1, 0);
    tick();
    touch_valid = 1'b0;
    chk_vict("s1_next", 1, 4);

    // Async reset mid-flush clears sets not yet swept
    touch(6, 0);
    chk_vict("s6_pre", 6, 4);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    chk("midflush_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    for (int s = 0; s < SETS; s++) chk_vict($sformatf("rst_mid_s%0d", s), s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_busy_after", int'(busy), 0);
    chk("rst_mid_vld_after", int'(victim_valid), 1);

`ifdef PLRU_WAY_LOCK_EN
    lock_mask = 8'h0F;
    chk_vict("lock_0f", 0, 4);
    lock_mask = 8'hFE;
    chk_vict("lock_fe", 0, 0);
    lock_mask = 8'hFF;
    chk_vict("lock_ff_way", 0, 0);
    chk("lock_ff_vld", int'(victim_valid), 0);
    lock_mask = 8'h01;
    valid_vec = 8'hF0;
    chk_vict("lock_inv_skip", 0, 1);
    touch(0, 0);
    valid_vec = 8'hFE;
    chk_vict("lock_inv_walk", 0, 4);
    chk("lock_inv_vld", int'(victim_valid), 1);
    lock_mask = 8'h00;
    valid_vec = 8'hFF;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
